// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
package bcd_pkg;
  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;
  localparam int BCD_W  = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;
endpackage

// File: rtl/bcd_convert_seq_if.sv
// Request/result bundle between the divider (master) and the BCD converter (slave).
interface bcd_convert_seq_if #(
  parameter int WIDTH  = bcd_pkg::WIDTH,
  parameter int DIGITS = bcd_pkg::DIGITS
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: bump a digit by 3 when it is 5 or more.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_d,
  output logic [BCD_W-1:0] o_d
);
  assign o_d = (i_d >= BCD_W'(5)) ? i_d + BCD_W'(3) : i_d;
endmodule

// File: rtl/bcd_convert_seq.sv
// Sequential 16-bit binary to packed BCD converter, one shift-and-add-3 step per cycle.
module bcd_convert_seq #(
  parameter int WIDTH  = bcd_pkg::WIDTH,
  parameter int DIGITS = bcd_pkg::DIGITS
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  bcd_convert_seq_if.slave   bus
);
  import bcd_pkg::*;

  localparam int BW   = BCD_W * DIGITS;
  localparam int SR_W = BW + WIDTH;
  localparam int CW   = $clog2(WIDTH + 1);

  state_t          r_state, w_state_n;
  logic [SR_W-1:0] r_sr, w_sr_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;
  logic [BW-1:0]   r_bcd, w_bcd_n;

  logic [BW-1:0]   w_dig_adj;
  logic [SR_W-1:0] w_adj;
  logic [SR_W-1:0] w_shift;

  // All digit fields corrected in parallel before the shift
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .i_d (r_sr[WIDTH + BCD_W*g +: BCD_W]),
      .o_d (w_dig_adj[BCD_W*g +: BCD_W])
    );
  end

  assign w_adj   = {w_dig_adj, r_sr[WIDTH-1:0]};
  assign w_shift = w_adj << 1;

  always_comb begin
    w_state_n = r_state;
    w_sr_n    = r_sr;
    w_cnt_n   = r_cnt;
    w_busy_n  = r_busy;
    w_done_n  = 1'b0;
    w_bcd_n   = r_bcd;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_sr_n    = {{BW{1'b0}}, bus.bin};
          w_cnt_n   = CW'(WIDTH);
          w_busy_n  = 1'b1;
          w_state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_sr_n  = w_shift;
        w_cnt_n = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_bcd_n   = w_shift[SR_W-1 -: BW];
          w_done_n  = 1'b1;
          w_busy_n  = 1'b0;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
    end else begin
      r_state <= w_state_n;
      r_sr    <= w_sr_n;
      r_cnt   <= w_cnt_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_bcd   <= w_bcd_n;
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;
endmodule

// File: tb/tb_bcd_convert_seq.sv
// Directed and random checks of bcd_convert_seq against a divide-by-ten reference.
module tb_bcd_convert_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  int   done_cnt = 0;

  bcd_convert_seq_if ifc ();

  bcd_convert_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ifc.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (ifc.done === 1'b1) done_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int t;
    t = v;
    r = '0;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Called just after the accepting edge; returns cycles until done is seen
  task automatic wait_done(input int maxc, output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (ifc.done !== 1'b1 && cyc < maxc) begin
      if (ifc.busy !== 1'b1) busy_ok = 1'b0;
      tick();
      cyc++;
    end
  endtask

  task automatic convert(input string tag, input int v, input logic [19:0] exp);
    int cyc;
    bit bok;
    ifc.start = 1'b1;
    ifc.bin   = 16'(v);
    tick();
    ifc.start = 1'b0;
    wait_done(40, cyc, bok);
    chk({tag, "_lat"}, cyc, 16);
    chk({tag, "_busy"}, {31'd0, bok}, 1);
    chk({tag, "_bcd"}, {12'd0, ifc.bcd}, {12'd0, exp});
    chk({tag, "_busy_at_done"}, {31'd0, ifc.busy}, 0);
    tick();
    chk({tag, "_done_1cyc"}, {31'd0, ifc.done}, 0);
  endtask

  initial begin
    int cyc, snap, acc, v, gap;
    bit bok;
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.bin   = '0;
    tick(); tick();
    chk("rst_busy", {31'd0, ifc.busy}, 0);
    chk("rst_done", {31'd0, ifc.done}, 0);
    chk("rst_bcd",  {12'd0, ifc.bcd}, 0);
    rst_n = 1'b1;
    tick();

    convert("q870",  870,   20'h00870);
    convert("zero",  0,     20'h00000);
    convert("max",   65535, 20'h65535);
    convert("n9999", 9999,  20'h09999);
    convert("n10000", 10000, 20'h10000);

    // Reset during conversion clears a previous non-zero result
    ifc.start = 1'b1;
    ifc.bin   = 16'd870;
    tick();
    ifc.start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("midrst_busy", {31'd0, ifc.busy}, 0);
    chk("midrst_done", {31'd0, ifc.done}, 0);
    chk("midrst_bcd",  {12'd0, ifc.bcd}, 0);
    snap = done_cnt;
    repeat (20) tick();
    chk("midrst_no_done", done_cnt - snap, 0);

    // start during SHIFT is dropped
    ifc.start = 1'b1;
    ifc.bin   = 16'd42;
    tick();
    ifc.start = 1'b0;
    repeat (4) tick();
    ifc.start = 1'b1;
    ifc.bin   = 16'd1234;
    tick();
    ifc.start = 1'b0;
    wait_done(40, cyc, bok);
    chk("ign_lat", cyc, 11);
    chk("ign_bcd", {12'd0, ifc.bcd}, 32'h00042);
    snap = done_cnt;
    repeat (20) tick();
    chk("ign_no_done", done_cnt - snap, 1);
    chk("ign_hold", {12'd0, ifc.bcd}, 32'h00042);

    // Back-to-back with start held high
    ifc.start = 1'b1;
    ifc.bin   = 16'd1;
    tick();
    wait_done(40, cyc, bok);
    chk("b2b_lat1", cyc, 16);
    chk("b2b_bcd1", {12'd0, ifc.bcd}, 32'h00001);
    ifc.bin = 16'd59999;
    tick();
    ifc.start = 1'b0;
    chk("b2b_busy2", {31'd0, ifc.busy}, 1);
    wait_done(40, cyc, bok);
    chk("b2b_lat2", cyc, 16);
    chk("b2b_bcd2", {12'd0, ifc.bcd}, 32'h59999);
    tick();

    // Random values with random idle gaps
    snap = done_cnt;
    acc  = 0;
    for (int i = 0; i < 1000; i++) begin
      v   = int'($urandom_range(0, 65535));
      gap = int'($urandom_range(0, 3));
      repeat (gap) tick();
      ifc.start = 1'b1;
      ifc.bin   = 16'(v);
      tick();
      ifc.start = 1'b0;
      acc++;
      wait_done(40, cyc, bok);
      chk("rnd_bcd", {12'd0, ifc.bcd}, {12'd0, ref_bcd(v)});
    end
    tick();
    chk("rnd_done_count", done_cnt - snap, acc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
